operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 The block SHALL provide these ports (clock and reset first):
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- rs, rt, rd  in  2 each  source A, source B, destination register indices
- use_rs, use_rt  in  1 each  instruction reads rs / rt
- reg_write_in, mem_read_in  in  1 each  instruction writes rd / is a load
- imm_in  in  16  immediate
- rf_addr1, rf_addr2  out  2 each  register-file read indices
- rf_data1, rf_data2  in  16 each  register-file read data
- ex_rd, ex_reg_write, ex_mem_read, ex_result  in  2/1/1/16  EX-stage producer
- mem_rd, mem_reg_write, mem_result  in  2/1/16  MEM-stage producer
- out_valid  out  1  operand bundle valid
- out_ready  in  1  downstream accepts bundle
- out_a, out_b, out_imm  out  16 each  resolved operands and immediate
- out_rd, out_reg_write, out_mem_read  out  2/1/1  forwarded control
- stall_cnt  out  16  hazard-stall cycle count
REQ-002 Clock SHALL be clk; reset SHALL be reset_n, asynchronous, active-low.

Function
REQ-003 rf_addr1 SHALL equal rs and rf_addr2 SHALL equal rt, combinationally.
REQ-004 A source SHALL be "live" only when its use_ flag is 1; unused sources SHALL never cause a hazard.
REQ-005 A load-use hazard SHALL exist when ex_reg_write=1, ex_mem_read=1, and ex_rd equals a live source.
REQ-006 in_ready SHALL be (no hazard) AND (out_valid=0 OR out_ready=1).
REQ-007 On in_valid AND in_ready, the output registers SHALL capture the resolved bundle; out_valid SHALL be 1 next cycle.
REQ-008 When out_valid=1 AND out_ready=0, all out_ signals SHALL hold unchanged.
REQ-009 When a hazard exists AND (out_valid=0 OR out_ready=1), out_valid SHALL go to 0 next cycle (bubble); the instruction SHALL remain at the inputs and retry.
REQ-010 Operand resolution priority per live source SHALL be: EX match (ex_reg_write=1, ex_mem_read=0, ex_rd match) -> ex_result; else MEM match (mem_reg_write=1, mem_rd match) -> mem_result; else rf_data.
REQ-011 All 4 registers SHALL be general purpose; index 0 SHALL receive no special treatment.
REQ-012 A same-cycle write-back SHALL NOT be forwarded by this block; the register file writes on the falling edge, so rf_data already reflects it at the rising edge.
REQ-013 stall_cnt SHALL increment by 1 each cycle with in_valid=1 and a hazard, and SHALL saturate at 0xFFFF.
REQ-014 out_reg_write and out_mem_read SHALL be 0 whenever out_valid=0.

Reset
REQ-015 While reset_n=0, out_valid, out_a, out_b, out_imm, out_rd, out_reg_write, out_mem_read and stall_cnt SHALL be 0, asynchronously.
REQ-016 Reset asserted mid-stall or mid-backpressure SHALL discard the held bundle; the first capture after release SHALL follow REQ-007.

Configuration
REQ-017 Forwarding SHALL be controlled by macro OPERAND_FORWARDING_EN.
- Defined: REQ-005 and REQ-010 apply.
- Undefined: any live-source match with (ex_reg_write=1, ex_rd) or (mem_reg_write=1, mem_rd) SHALL be a hazard, and operands SHALL always come from rf_data.

Verification
REQ-018 Forwarding EX over MEM: rs=1, use_rs=1, ex_rd=1, ex_reg_write=1, ex_result=0x1234, mem_rd=1, mem_reg_write=1, mem_result=0x5678 -> out_a=0x1234.
REQ-019 Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=2, rt=2, use_rt=1 -> in_ready=0, one bubble (out_valid=0), stall_cnt=1; after ex_mem_read=0 the instruction is accepted.
REQ-020 Unused source: same as REQ-019 but use_rt=0 -> no stall, out_b=rf_data2.
REQ-021 Backpressure: out_valid=1, out_ready=0 for 3 cycles with new in_valid -> in_ready=0, out_ bundle constant; out_ready=1 -> next bundle captured.
REQ-022 Reset: reset_n=0 during backpressure with out_a=0xBEEF -> out_valid=0, out_a=0, stall_cnt=0 immediately, without waiting for clk.
REQ-023 Macro undefined: mem_rd=3, mem_reg_write=1, rs=3, use_rs=1 -> stall until mem_reg_write=0; out_a=rf_data1.

Source files
------------

// File: rtl/operand_stage.sv
// Operand stage: register-file read, hazard detection, operand forwarding, and a registered output bundle with valid/ready.
// Build option: define OPERAND_FORWARDING_EN to forward from EX/MEM; otherwise any producer match on a live source stalls.
module operand_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  rs,
    input  logic [1:0]  rt,
    input  logic [1:0]  rd,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic [15:0] imm_in,
    output logic [1:0]  rf_addr1,
    output logic [1:0]  rf_addr2,
    input  logic [15:0] rf_data1,
    input  logic [15:0] rf_data2,
    input  logic [1:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [15:0] ex_result,
    input  logic [1:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [15:0] mem_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic [15:0] out_imm,
    output logic [1:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic [15:0] stall_cnt
);

    // Source 0 is rs / port 1, source 1 is rt / port 2.
    logic [1:0][1:0]  src_idx;
    logic [1:0]       src_live;
    logic [1:0][15:0] src_rf;
    logic [1:0][15:0] src_val;
    logic [1:0]       src_haz;

    logic hazard;
    logic advance;
    logic accept;

    logic        out_valid_q, out_valid_d;
    logic [15:0] out_a_q, out_a_d;
    logic [15:0] out_b_q, out_b_d;
    logic [15:0] out_imm_q, out_imm_d;
    logic [1:0]  out_rd_q, out_rd_d;
    logic        out_rw_q, out_rw_d;
    logic        out_mr_q, out_mr_d;
    logic [15:0] stall_q, stall_d;

    assign rf_addr1 = rs;
    assign rf_addr2 = rt;

    assign src_idx  = {rt, rs};
    assign src_live = {use_rt, use_rs};
    assign src_rf   = {rf_data2, rf_data1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic ex_hit;
            logic mem_hit;

            assign ex_hit  = src_live[gi] && ex_reg_write && (ex_rd == src_idx[gi]);
            assign mem_hit = src_live[gi] && mem_reg_write && (mem_rd == src_idx[gi]);
`ifdef OPERAND_FORWARDING_EN
            // A load in EX has no data yet, so only that case stalls; EX wins over MEM.
            assign src_haz[gi] = ex_hit && ex_mem_read;
            assign src_val[gi] = (ex_hit && !ex_mem_read) ? ex_result :
                                 mem_hit                  ? mem_result :
                                                            src_rf[gi];
`else
            assign src_haz[gi] = ex_hit || mem_hit;
            assign src_val[gi] = src_rf[gi];
`endif
        end
    endgenerate

`ifndef OPERAND_FORWARDING_EN
    logic fwd_unused;
    assign fwd_unused = ^{ex_mem_read, ex_result, mem_result};
`endif

    assign hazard   = |src_haz;
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = !hazard && advance;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_imm_d   = out_imm_q;
        out_rd_d    = out_rd_q;
        out_rw_d    = out_rw_q;
        out_mr_d    = out_mr_q;
        stall_d     = stall_q;

        // When the slot frees up without a new capture, emit a bubble with its controls cleared.
        if (advance) begin
            out_valid_d = accept;
            out_rw_d    = 1'b0;
            out_mr_d    = 1'b0;
            if (accept) begin
                out_a_d   = src_val[0];
                out_b_d   = src_val[1];
                out_imm_d = imm_in;
                out_rd_d  = rd;
                out_rw_d  = reg_write_in;
                out_mr_d  = mem_read_in;
            end
        end

        if (in_valid && hazard && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= 16'd0;
            out_b_q     <= 16'd0;
            out_imm_q   <= 16'd0;
            out_rd_q    <= 2'd0;
            out_rw_q    <= 1'b0;
            out_mr_q    <= 1'b0;
            stall_q     <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_imm_q   <= out_imm_d;
            out_rd_q    <= out_rd_d;
            out_rw_q    <= out_rw_d;
            out_mr_q    <= out_mr_d;
            stall_q     <= stall_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_a         = out_a_q;
    assign out_b         = out_b_q;
    assign out_imm       = out_imm_q;
    assign out_rd        = out_rd_q;
    assign out_reg_write = out_rw_q;
    assign out_mem_read  = out_mr_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: vector table plus hand sequences for stalls, backpressure and async reset.
// Expectations follow the OPERAND_FORWARDING_EN build option.
module tb_operand_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  rs, rt, rd;
    logic        use_rs, use_rt;
    logic        reg_write_in, mem_read_in;
    logic [15:0] imm_in;
    logic [1:0]  rf_addr1, rf_addr2;
    logic [15:0] rf_data1, rf_data2;
    logic [1:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read;
    logic [15:0] ex_result;
    logic [1:0]  mem_rd;
    logic        mem_reg_write;
    logic [15:0] mem_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a, out_b, out_imm;
    logic [1:0]  out_rd;
    logic        out_reg_write, out_mem_read;
    logic [15:0] stall_cnt;

    operand_stage dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .rt(rt), .rd(rd),
        .use_rs(use_rs), .use_rt(use_rt),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .imm_in(imm_in),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rs, rt, rd;
        logic        urs, urt, rw, mr;
        logic [15:0] imm, rf1, rf2;
        logic [1:0]  exrd;
        logic        exw, exmr;
        logic [15:0] exres;
        logic [1:0]  memrd;
        logic        memw;
        logic [15:0] memres;
        logic        hz_f;
        logic [15:0] a_f, b_f;
        logic        hz_n;
    } vec_t;

    typedef struct {
        logic [15:0] a, b, imm;
        logic [1:0]  rd;
        logic        rw, mr;
    } bundle_t;

    bundle_t     sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ntx = 0;
    logic        exp_valid = 1'b0;
    logic [15:0] exp_stall = 16'd0;
    vec_t        vecs[9];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; rs = 2'd0; rt = 2'd0; rd = 2'd0;
        use_rs = 1'b0; use_rt = 1'b0; reg_write_in = 1'b0; mem_read_in = 1'b0;
        imm_in = 16'd0; rf_data1 = 16'd0; rf_data2 = 16'd0;
        ex_rd = 2'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_result = 16'd0;
        mem_rd = 2'd0; mem_reg_write = 1'b0; mem_result = 16'd0;
    endtask

    task automatic apply(input vec_t v);
        in_valid = 1'b1; rs = v.rs; rt = v.rt; rd = v.rd;
        use_rs = v.urs; use_rt = v.urt; reg_write_in = v.rw; mem_read_in = v.mr;
        imm_in = v.imm; rf_data1 = v.rf1; rf_data2 = v.rf2;
        ex_rd = v.exrd; ex_reg_write = v.exw; ex_mem_read = v.exmr; ex_result = v.exres;
        mem_rd = v.memrd; mem_reg_write = v.memw; mem_result = v.memres;
    endtask

    // Without forwarding the operands always come straight from the register file.
    task automatic expect_of(input vec_t v, output logic hz, output logic [15:0] ea, output logic [15:0] eb);
`ifdef OPERAND_FORWARDING_EN
        hz = v.hz_f; ea = v.a_f; eb = v.b_f;
`else
        hz = v.hz_n; ea = v.rf1; eb = v.rf2;
`endif
    endtask

    // Called just after an active edge with inputs already driven; runs one clock.
    task automatic tick(input logic hz, input logic [15:0] ea, input logic [15:0] eb);
        bundle_t nb;
        bundle_t f;
        logic    exp_ready;
        #1;
        exp_ready = !hz && (!exp_valid || out_ready);
        chk("in_ready", 16'(in_ready), 16'(exp_ready));
        chk("rf_addr1", 16'(rf_addr1), 16'(rs));
        chk("rf_addr2", 16'(rf_addr2), 16'(rt));
        if (exp_valid && out_ready && sb.size() > 0) begin
            f = sb.pop_front();
            $display("tx %0d a=%h b=%h imm=%h rd=%0d rw=%0b mr=%0b", ntx, f.a, f.b, f.imm, f.rd, f.rw, f.mr);
            ntx++;
        end
        if (in_valid && exp_ready) begin
            nb.a = ea; nb.b = eb; nb.imm = imm_in; nb.rd = rd; nb.rw = reg_write_in; nb.mr = mem_read_in;
            sb.push_back(nb);
        end
        if (in_valid && hz && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
        exp_valid = (in_valid && exp_ready) || (exp_valid && !out_ready);
        @(posedge clk);
        #1;
        chk("out_valid", 16'(out_valid), 16'(exp_valid));
        chk("stall_cnt", stall_cnt, exp_stall);
        if (exp_valid && sb.size() > 0) begin
            chk("out_a", out_a, sb[0].a);
            chk("out_b", out_b, sb[0].b);
            chk("out_imm", out_imm, sb[0].imm);
            chk("out_rd", 16'(out_rd), 16'(sb[0].rd));
            chk("out_reg_write", 16'(out_reg_write), 16'(sb[0].rw));
            chk("out_mem_read", 16'(out_mem_read), 16'(sb[0].mr));
        end else begin
            chk("bubble_reg_write", 16'(out_reg_write), 16'd0);
            chk("bubble_mem_read", 16'(out_mem_read), 16'd0);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_a", out_a, 16'd0);
        chk("rst_out_b", out_b, 16'd0);
        chk("rst_out_imm", out_imm, 16'd0);
        chk("rst_out_rd", 16'(out_rd), 16'd0);
        chk("rst_out_reg_write", 16'(out_reg_write), 16'd0);
        chk("rst_out_mem_read", 16'(out_mem_read), 16'd0);
        chk("rst_stall_cnt", stall_cnt, 16'd0);
    endtask

    initial begin
        logic        hz;
        logic [15:0] ea, eb;

        //          rs    rt    rd    urs   urt   rw    mr    imm       rf1       rf2       exrd  exw   exmr  exres     memrd memw  memres    hz_f  a_f       b_f       hz_n
        vecs[0] = '{2'd1, 2'd2, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h1111, 16'h2222, 2'd0, 1'b0, 1'b0, 16'hE000, 2'd0, 1'b0, 16'hD000, 1'b0, 16'h1111, 16'h2222, 1'b0};
        vecs[1] = '{2'd1, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0101, 16'h0202, 2'd1, 1'b1, 1'b0, 16'h1234, 2'd1, 1'b1, 16'h5678, 1'b0, 16'h1234, 16'h0202, 1'b1};
        vecs[2] = '{2'd0, 2'd3, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0303, 16'h0404, 2'd2, 1'b1, 1'b0, 16'hE002, 2'd3, 1'b1, 16'h5A5A, 1'b0, 16'h0303, 16'h5A5A, 1'b1};
        vecs[3] = '{2'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0505, 16'h0606, 2'd2, 1'b1, 1'b1, 16'hE003, 2'd1, 1'b1, 16'hD003, 1'b0, 16'h0505, 16'h0606, 1'b0};
        vecs[4] = '{2'd0, 2'd1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0707, 16'h0808, 2'd0, 1'b1, 1'b0, 16'hABCD, 2'd1, 1'b1, 16'h4321, 1'b0, 16'hABCD, 16'h4321, 1'b1};
        vecs[5] = '{2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h0909, 16'h0A0A, 2'd1, 1'b0, 1'b1, 16'hE005, 2'd1, 1'b0, 16'hD005, 1'b0, 16'h0909, 16'h0A0A, 1'b0};
        vecs[6] = '{2'd3, 2'd3, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0050, 16'h0B0B, 16'h0C0C, 2'd3, 1'b1, 1'b1, 16'hE006, 2'd0, 1'b0, 16'hD006, 1'b1, 16'h0000, 16'h0000, 1'b1};
        vecs[7] = '{2'd2, 2'd1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0060, 16'h0D0D, 16'h0E0E, 2'd1, 1'b1, 1'b0, 16'h1357, 2'd2, 1'b1, 16'h2468, 1'b0, 16'h2468, 16'h1357, 1'b1};
        vecs[8] = '{2'd2, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0070, 16'h0F0F, 16'h1010, 2'd2, 1'b1, 1'b1, 16'hE008, 2'd2, 1'b1, 16'hD008, 1'b0, 16'h0F0F, 16'h1010, 1'b0};

        idle_inputs();
        out_ready = 1'b1;
        reset_n   = 1'b0;
        #3;
        chk_reset_values();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, downstream always ready.
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i]);
            expect_of(vecs[i], hz, ea, eb);
            tick(hz, ea, eb);
        end
        idle_inputs();
        tick(1'b0, 16'd0, 16'd0);

        // Load-use on rt, then the load leaves EX.
        idle_inputs();
        in_valid = 1'b1; rt = 2'd2; use_rt = 1'b1; rd = 2'd1; reg_write_in = 1'b1; imm_in = 16'h0101;
        rf_data1 = 16'h0111; rf_data2 = 16'h0222;
        ex_rd = 2'd2; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_result = 16'h0E0E;
        tick(1'b1, 16'd0, 16'd0);
        ex_mem_read = 1'b0;
`ifdef OPERAND_FORWARDING_EN
        tick(1'b0, 16'h0111, 16'h0E0E);
`else
        tick(1'b1, 16'd0, 16'd0);
        ex_reg_write = 1'b0;
        tick(1'b0, 16'h0111, 16'h0222);
`endif
        idle_inputs();
        tick(1'b0, 16'd0, 16'd0);

        // MEM-stage producer on rs.
        in_valid = 1'b1; rs = 2'd3; use_rs = 1'b1; rd = 2'd0; imm_in = 16'h0303;
        rf_data1 = 16'h3333; rf_data2 = 16'h4444;
        mem_rd = 2'd3; mem_reg_write = 1'b1; mem_result = 16'h7777;
`ifdef OPERAND_FORWARDING_EN
        tick(1'b0, 16'h7777, 16'h4444);
`else
        tick(1'b1, 16'd0, 16'd0);
        tick(1'b1, 16'd0, 16'd0);
        mem_reg_write = 1'b0;
        tick(1'b0, 16'h3333, 16'h4444);
`endif
        idle_inputs();
        tick(1'b0, 16'd0, 16'd0);

        // Backpressure: bundle A held for three cycles while B waits.
        out_ready = 1'b1;
        in_valid = 1'b1; rs = 2'd1; rt = 2'd2; use_rs = 1'b1; use_rt = 1'b1; rd = 2'd3;
        reg_write_in = 1'b1; mem_read_in = 1'b1; imm_in = 16'h00AA; rf_data1 = 16'hA1A1; rf_data2 = 16'hA2A2;
        tick(1'b0, 16'hA1A1, 16'hA2A2);
        out_ready = 1'b0;
        rd = 2'd2; reg_write_in = 1'b0; mem_read_in = 1'b0; imm_in = 16'h00BB; rf_data1 = 16'hB1B1; rf_data2 = 16'hB2B2;
        for (int k = 0; k < 3; k++) tick(1'b0, 16'hB1B1, 16'hB2B2);
        out_ready = 1'b1;
        tick(1'b0, 16'hB1B1, 16'hB2B2);
        idle_inputs();
        tick(1'b0, 16'd0, 16'd0);

        // Async reset while a bundle is held and a hazard is stalling the input.
        out_ready = 1'b0;
        in_valid = 1'b1; rs = 2'd0; use_rs = 1'b1; rd = 2'd1; reg_write_in = 1'b1; imm_in = 16'h00EE;
        rf_data1 = 16'hBEEF; rf_data2 = 16'h0BAD;
        tick(1'b0, 16'hBEEF, 16'h0BAD);
        rs = 2'd1; ex_rd = 2'd1; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        tick(1'b1, 16'd0, 16'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values();
        sb.delete();
        exp_valid = 1'b0;
        exp_stall = 16'd0;
        idle_inputs();
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_out_valid", 16'(out_valid), 16'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; rs = 2'd2; rt = 2'd3; use_rs = 1'b1; use_rt = 1'b1; rd = 2'd2;
        mem_read_in = 1'b1; imm_in = 16'h0C0C; rf_data1 = 16'hC1C1; rf_data2 = 16'hC2C2;
        tick(1'b0, 16'hC1C1, 16'hC2C2);
        idle_inputs();
        tick(1'b0, 16'd0, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
